// File: rtl/frame_sequencer.sv
// Per-frame camera sequencer: moves the camera by button input, starts the environment
// stream, waits for stream and obstacle collection, then commits the new camera position.
module frame_sequencer #(
  parameter int WORLD_BITS     = 18,
  parameter int CAM_STEP       = 5,
  parameter int CAM_MIN        = -100000,
  parameter int CAM_MAX        = 100000,
  parameter int CAM_INIT_X     = 640,
  parameter int CAM_INIT_Y     = 360,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         new_frame_in,
  input  logic [3:0]                   btn_in,
  output logic                         env_start_out,
  input  logic                         env_done_in,
  input  logic                         obs_done_in,
  output logic signed [WORLD_BITS-1:0] camera_x_out,
  output logic signed [WORLD_BITS-1:0] camera_y_out,
  output logic signed [WORLD_BITS-1:0] pending_x_out,
  output logic signed [WORLD_BITS-1:0] pending_y_out,
  output logic                         swap_out,
  output logic                         busy_out,
  output logic                         timeout_out,
  output logic [7:0]                   drops_out,
  output logic [1:0]                   state_out
);

  localparam int CNT_BITS = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic signed [WORLD_BITS:0]   MIN_W  = CAM_MIN[WORLD_BITS:0];
  localparam logic signed [WORLD_BITS:0]   MAX_W  = CAM_MAX[WORLD_BITS:0];
  localparam logic signed [WORLD_BITS-1:0] STEP_W = CAM_STEP[WORLD_BITS-1:0];
  localparam logic signed [WORLD_BITS-1:0] INIT_X = CAM_INIT_X[WORLD_BITS-1:0];
  localparam logic signed [WORLD_BITS-1:0] INIT_Y = CAM_INIT_Y[WORLD_BITS-1:0];
  localparam logic [CNT_BITS-1:0]          CNT_LAST = CNT_BITS'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, STREAM = 2'd1, COLLECT = 2'd2, COMMIT = 2'd3} state_t;

  state_t                        state, state_nxt;
  logic signed [WORLD_BITS-1:0]  cam_x_nxt, cam_y_nxt, pend_x_nxt, pend_y_nxt;
  logic signed [WORLD_BITS-1:0]  dx, dy, move_x, move_y;
  logic                          env_start_nxt, swap_nxt, busy_nxt, timeout_nxt;
  logic                          obs_seen, obs_seen_nxt;
  logic [CNT_BITS-1:0]           cnt, cnt_nxt;
  logic [7:0]                    drops_nxt;
  logic                          cnt_expired;

  // Sum one extra bit wide so an overflow past the bounds clamps instead of wrapping.
  function automatic logic signed [WORLD_BITS-1:0] clamp_add(
    input logic signed [WORLD_BITS-1:0] base,
    input logic signed [WORLD_BITS-1:0] step
  );
    logic signed [WORLD_BITS:0] sum;
    sum = $signed({base[WORLD_BITS-1], base}) + $signed({step[WORLD_BITS-1], step});
    if (sum > MAX_W)      return MAX_W[WORLD_BITS-1:0];
    else if (sum < MIN_W) return MIN_W[WORLD_BITS-1:0];
    else                  return sum[WORLD_BITS-1:0];
  endfunction

  always_comb begin
    dx = '0;
    dy = '0;
    if (btn_in[3])      dx = -STEP_W;
    else if (btn_in[2]) dx = STEP_W;
    else if (btn_in[1]) dy = -STEP_W;
    else if (btn_in[0]) dy = STEP_W;
  end

  assign move_x      = clamp_add(camera_x_out, dx);
  assign move_y      = clamp_add(camera_y_out, dy);
  assign cnt_expired = (cnt >= CNT_LAST);
  assign state_out   = state;

  always_comb begin
    state_nxt     = state;
    cam_x_nxt     = camera_x_out;
    cam_y_nxt     = camera_y_out;
    pend_x_nxt    = pending_x_out;
    pend_y_nxt    = pending_y_out;
    env_start_nxt = 1'b0;
    swap_nxt      = 1'b0;
    timeout_nxt   = 1'b0;
    obs_seen_nxt  = obs_seen;
    cnt_nxt       = cnt;
    drops_nxt     = drops_out;

    if (new_frame_in && (state != IDLE) && (drops_out != 8'hFF))
      drops_nxt = drops_out + 8'd1;

    case (state)
      IDLE: begin
        if (new_frame_in) begin
          pend_x_nxt    = move_x;
          pend_y_nxt    = move_y;
          env_start_nxt = 1'b1;
          cnt_nxt       = '0;
          obs_seen_nxt  = 1'b0;
          state_nxt     = STREAM;
        end
      end
      STREAM: begin
        cnt_nxt = cnt + 1'b1;
        if (obs_done_in) obs_seen_nxt = 1'b1;
        // A done input beats an expiring counter in the same cycle.
        if (env_done_in) begin
          state_nxt = COLLECT;
        end else if (cnt_expired) begin
          state_nxt    = IDLE;
          timeout_nxt  = 1'b1;
          pend_x_nxt   = camera_x_out;
          pend_y_nxt   = camera_y_out;
          obs_seen_nxt = 1'b0;
        end
      end
      COLLECT: begin
        cnt_nxt = cnt + 1'b1;
        if (obs_done_in || obs_seen) begin
          cam_x_nxt = pending_x_out;
          cam_y_nxt = pending_y_out;
          swap_nxt  = 1'b1;
          state_nxt = COMMIT;
        end else if (cnt_expired) begin
          state_nxt    = IDLE;
          timeout_nxt  = 1'b1;
          pend_x_nxt   = camera_x_out;
          pend_y_nxt   = camera_y_out;
          obs_seen_nxt = 1'b0;
        end
      end
      COMMIT: begin
        state_nxt    = IDLE;
        obs_seen_nxt = 1'b0;
      end
      default: state_nxt = IDLE;
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state         <= IDLE;
      camera_x_out  <= INIT_X;
      camera_y_out  <= INIT_Y;
      pending_x_out <= INIT_X;
      pending_y_out <= INIT_Y;
      env_start_out <= 1'b0;
      swap_out      <= 1'b0;
      busy_out      <= 1'b0;
      timeout_out   <= 1'b0;
      drops_out     <= 8'd0;
      obs_seen      <= 1'b0;
      cnt           <= '0;
    end else begin
      state         <= state_nxt;
      camera_x_out  <= cam_x_nxt;
      camera_y_out  <= cam_y_nxt;
      pending_x_out <= pend_x_nxt;
      pending_y_out <= pend_y_nxt;
      env_start_out <= env_start_nxt;
      swap_out      <= swap_nxt;
      busy_out      <= busy_nxt;
      timeout_out   <= timeout_nxt;
      drops_out     <= drops_nxt;
      obs_seen      <= obs_seen_nxt;
      cnt           <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_frame_sequencer.sv
// Bench for frame_sequencer: default-parameter instance plus a small-bound/short-timeout
// instance sharing the same stimulus; committed cameras are scoreboarded on swap_out.
module tb_frame_sequencer;
  localparam int WB = 18;

  logic clk_in = 1'b0;
  logic rst_in, new_frame_in, env_done_in, obs_done_in;
  logic [3:0] btn_in;

  logic                 env_start_out, swap_out, busy_out, timeout_out;
  logic signed [WB-1:0] camera_x_out, camera_y_out, pending_x_out, pending_y_out;
  logic [7:0]           drops_out;
  logic [1:0]           state_out;

  logic                 s_env_start, s_swap, s_busy, s_timeout;
  logic signed [WB-1:0] s_cam_x, s_cam_y, s_pend_x, s_pend_y;
  logic [7:0]           s_drops;
  logic [1:0]           s_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [2*WB-1:0] exp_q[$];

  int swap_at, start_at, starts, swaps, s_swap_at, s_swaps, s_tmo_at;
  logic signed [WB-1:0] pend1_x, pend1_y;

  frame_sequencer dut (
    .clk_in(clk_in), .rst_in(rst_in), .new_frame_in(new_frame_in), .btn_in(btn_in),
    .env_start_out(env_start_out), .env_done_in(env_done_in), .obs_done_in(obs_done_in),
    .camera_x_out(camera_x_out), .camera_y_out(camera_y_out),
    .pending_x_out(pending_x_out), .pending_y_out(pending_y_out),
    .swap_out(swap_out), .busy_out(busy_out), .timeout_out(timeout_out),
    .drops_out(drops_out), .state_out(state_out)
  );

  frame_sequencer #(.CAM_MAX(642), .TIMEOUT_CYCLES(20)) dut_s (
    .clk_in(clk_in), .rst_in(rst_in), .new_frame_in(new_frame_in), .btn_in(btn_in),
    .env_start_out(s_env_start), .env_done_in(env_done_in), .obs_done_in(obs_done_in),
    .camera_x_out(s_cam_x), .camera_y_out(s_cam_y),
    .pending_x_out(s_pend_x), .pending_y_out(s_pend_y),
    .swap_out(s_swap), .busy_out(s_busy), .timeout_out(s_timeout),
    .drops_out(s_drops), .state_out(s_state)
  );

  // clock / reset
  always #5 clk_in = ~clk_in;

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish before 500000");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic reset_dut();
    rst_in = 1'b1; new_frame_in = 1'b0; env_done_in = 1'b0; obs_done_in = 1'b0; btn_in = 4'd0;
    repeat (2) tick();
    rst_in = 1'b0;
    tick();
  endtask

  // Cycle c is the cycle after the c-th edge; new_frame is driven in cycle 0.
  task automatic run_frame(input logic [3:0] btn, input int env_at, input int obs_at, input int n_cyc);
    swap_at = -1; start_at = -1; starts = 0; swaps = 0;
    s_swap_at = -1; s_swaps = 0; s_tmo_at = -1;
    for (int c = 0; c < n_cyc; c++) begin
      if (swap_out) begin swaps++; if (swap_at < 0) swap_at = c; end
      if (env_start_out) begin starts++; if (start_at < 0) start_at = c; end
      if (c == 1) begin pend1_x = pending_x_out; pend1_y = pending_y_out; end
      if (s_swap) begin s_swaps++; if (s_swap_at < 0) s_swap_at = c; end
      if (s_timeout && s_tmo_at < 0) s_tmo_at = c;
      new_frame_in = (c == 0);
      btn_in       = (c == 0) ? btn : 4'($urandom_range(0, 15));
      env_done_in  = (c == env_at);
      obs_done_in  = (c == obs_at);
      tick();
    end
    new_frame_in = 1'b0; env_done_in = 1'b0; obs_done_in = 1'b0; btn_in = 4'd0;
  endtask

  // scoreboard: committed camera popped on every swap of the default instance
  always @(negedge clk_in) begin
    if (!rst_in && swap_out) begin
      if (exp_q.size() == 0) check("unexpected_swap", 64'd1, 64'd0);
      else check("sb_camera", {camera_x_out, camera_y_out}, exp_q.pop_front());
    end
  end

  initial begin
    int sw;
    // reset values, checked while reset is still asserted
    rst_in = 1'b1; new_frame_in = 1'b0; env_done_in = 1'b0; obs_done_in = 1'b0; btn_in = 4'd0;
    #2;
    check("rst_cam_x", camera_x_out, 640);
    check("rst_cam_y", camera_y_out, 360);
    check("rst_pend_x", pending_x_out, 640);
    check("rst_pend_y", pending_y_out, 360);
    check("rst_flags", {env_start_out, swap_out, busy_out, timeout_out}, 0);
    check("rst_drops", drops_out, 0);
    check("rst_state", state_out, 0);
    reset_dut();

    // done inputs are ignored in IDLE
    env_done_in = 1'b1; obs_done_in = 1'b1;
    tick(); tick();
    env_done_in = 1'b0; obs_done_in = 1'b0;
    check("idle_ignore_busy", busy_out, 0);
    check("idle_ignore_swap", swap_out, 0);

    // nominal frame: env_done 10 cycles after env_start, obs_done 5 after that
    exp_q.push_back({WB'(645), WB'(360)});
    run_frame(4'b0100, 11, 16, 30);
    check("nom_start_at", start_at, 1);
    check("nom_starts", starts, 1);
    check("nom_pend_x", pend1_x, 645);
    check("nom_swap_at", swap_at, 17);
    check("nom_swaps", swaps, 1);
    check("nom_cam_x", camera_x_out, 645);
    check("nom_cam_y", camera_y_out, 360);
    check("nom_busy", busy_out, 0);

    // clamp at CAM_MAX=642 over two frames
    reset_dut();
    exp_q.push_back({WB'(645), WB'(360)});
    run_frame(4'b0100, 3, 5, 12);
    check("clamp1_swaps", s_swaps, 1);
    check("clamp1_cam_x", s_cam_x, 642);
    exp_q.push_back({WB'(650), WB'(360)});
    run_frame(4'b0100, 3, 5, 12);
    check("clamp2_swaps", s_swaps, 1);
    check("clamp2_cam_x", s_cam_x, 642);
    check("clamp2_cam_y", s_cam_y, 360);

    // timeout with env_done never asserted
    reset_dut();
    run_frame(4'b0100, -1, -1, 40);
    check("tmo_at", s_tmo_at, 21);
    check("tmo_swaps", s_swaps, 0);
    check("tmo_cam_x", s_cam_x, 640);
    check("tmo_pend_x", s_pend_x, 640);
    check("tmo_busy", s_busy, 0);
    check("tmo_long_busy", busy_out, 1);

    // early obs_done together with env_done
    reset_dut();
    exp_q.push_back({WB'(640), WB'(365)});
    run_frame(4'b0001, 5, 5, 15);
    check("early_swap_at", swap_at, 7);
    check("early_swaps", swaps, 1);
    check("early_cam_y", camera_y_out, 365);

    // 300 frame pulses while busy
    reset_dut();
    new_frame_in = 1'b1; btn_in = 4'b0010;
    tick();
    check("drop_start", env_start_out, 1);
    check("drop_state", state_out, 1);
    starts = 0;
    for (int i = 0; i < 300; i++) begin
      btn_in = 4'($urandom_range(0, 15));
      tick();
      if (env_start_out) starts++;
    end
    new_frame_in = 1'b0;
    tick();
    check("drop_count", drops_out, 255);
    check("drop_restarts", starts, 0);
    check("drop_still_stream", state_out, 1);
    exp_q.push_back({WB'(640), WB'(355)});
    env_done_in = 1'b1; tick();
    env_done_in = 1'b0; obs_done_in = 1'b1; tick();
    obs_done_in = 1'b0;
    check("drop_commit_swap", swap_out, 1);
    tick();
    check("drop_cam_y", camera_y_out, 355);
    check("drop_idle", busy_out, 0);

    // reset asserted while in COLLECT
    reset_dut();
    new_frame_in = 1'b1; btn_in = 4'b0100; tick();
    new_frame_in = 1'b0; env_done_in = 1'b1; tick();
    env_done_in = 1'b0; tick();
    check("rc_state_collect", state_out, 2);
    rst_in = 1'b1; obs_done_in = 1'b1;
    #1;
    check("rc_async_state", state_out, 0);
    check("rc_async_pend_x", pending_x_out, 640);
    check("rc_async_busy", busy_out, 0);
    sw = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (swap_out) sw++;
    end
    check("rc_no_swap", sw, 0);
    check("rc_cam_x", camera_x_out, 640);
    rst_in = 1'b0; obs_done_in = 1'b0;
    tick();
    check("rc_drops", drops_out, 0);
    exp_q.push_back({WB'(635), WB'(360)});
    run_frame(4'b1000, 11, 16, 30);
    check("rc_next_start", start_at, 1);
    check("rc_next_swap_at", swap_at, 17);
    check("rc_next_cam_x", camera_x_out, 635);

    check("sb_queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
